// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: framed SPI command parser, config register file and count readout.
// Define SPI_CMD_CHKSUM_EN to add an XOR checksum byte to WRITE/READ/COUNT frames.

module spi_cmd_decoder #(
    parameter int         NREG      = 4,
    parameter logic [3:0] STATUS_ID = 4'hA,
    localparam int        AW        = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                 sysClk,
    input  logic                 reset,
    input  logic [7:0]           rx,
    input  logic                 rxValid,
    input  logic                 ss_active,
    input  logic [31:0]          count,
    input  logic                 count_valid,
    output logic [7:0]           tx,
    output logic [32*NREG-1:0]   regs,
    output logic                 wr_stb,
    output logic [AW-1:0]        wr_addr
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_CHK, S_DRAIN} state_t;
    typedef enum logic [1:0] {OP_WR, OP_RD, OP_CNT} op_t;

`ifdef SPI_CMD_CHKSUM_EN
    localparam int WDW = 32;
`else
    localparam int WDW = 24;
`endif

    localparam logic [31:0] NREG_W = NREG;

    state_t           state_q, state_d;
    op_t              op_q;
    logic [1:0]       idx_q;
    logic [AW-1:0]    addr_q;
    logic             addr_ok_q;
    logic [WDW-1:0]   wdata_q;
    logic [31:0]      word_q;
    logic [7:0]       tx_q;
    logic             tx_stat_q;
    logic             err_q;
    logic [31:0]      reg_q [NREG];

    logic             addr_ok;
    logic [31:0]      rd_word;
    logic             commit;
    logic [31:0]      commit_data;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
        case (k)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

`ifdef SPI_CMD_CHKSUM_EN
    function automatic logic [7:0] xor4(input logic [31:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction
`endif

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign regs[32*g +: 32] = reg_q[g];
    end

    assign addr_ok = {24'd0, rx} < NREG_W;
    assign rd_word = addr_ok ? reg_q[rx[AW-1:0]] : 32'h0;
    assign tx      = tx_stat_q ? {STATUS_ID, 2'b00, err_q, count_valid} : tx_q;

    // state register
    always_ff @(posedge sysClk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // next state and write-commit decision
    always_comb begin
        state_d     = state_q;
        commit      = 1'b0;
        commit_data = {wdata_q[23:0], rx};
        if (!ss_active) begin
            state_d = S_IDLE;
        end else if (rxValid) begin
            unique case (state_q)
                S_IDLE: begin
                    case (rx)
                        8'h01, 8'h02: state_d = S_ADDR;
                        8'h03:        state_d = S_DATA;
                        default:      state_d = S_DRAIN;
                    endcase
                end
                S_ADDR: state_d = S_DATA;
                S_DATA: begin
                    if (idx_q == 2'd3) begin
`ifdef SPI_CMD_CHKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DRAIN;
                        commit  = (op_q == OP_WR) && addr_ok_q;
`endif
                    end
                end
                S_CHK: begin
                    state_d = S_DRAIN;
`ifdef SPI_CMD_CHKSUM_EN
                    commit_data = wdata_q;
                    commit = (op_q == OP_WR) && addr_ok_q && (rx == xor4(wdata_q));
`endif
                end
                S_DRAIN: state_d = S_DRAIN;
            endcase
        end
    end

    // payload capture, tx byte staging, error flag and register commit
    always_ff @(posedge sysClk or posedge reset) begin
        if (reset) begin
            op_q      <= OP_WR;
            idx_q     <= 2'd0;
            addr_q    <= '0;
            addr_ok_q <= 1'b0;
            wdata_q   <= '0;
            word_q    <= 32'h0;
            tx_q      <= 8'h00;
            tx_stat_q <= 1'b1;
            err_q     <= 1'b0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            for (int i = 0; i < NREG; i++) reg_q[i] <= 32'h0;
        end else begin
            wr_stb <= 1'b0;
            if (!ss_active) begin
                tx_stat_q <= 1'b1;
                tx_q      <= 8'h00;
                idx_q     <= 2'd0;
                wdata_q   <= '0;
            end else if (rxValid) begin
                tx_stat_q <= 1'b0;
                tx_q      <= 8'h00;
                unique case (state_q)
                    S_IDLE: begin
                        idx_q <= 2'd0;
                        case (rx)
                            8'h01: op_q <= OP_WR;
                            8'h02: op_q <= OP_RD;
                            8'h03: begin
                                op_q   <= OP_CNT;
                                word_q <= count;
                                tx_q   <= count[31:24];
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                    S_ADDR: begin
                        addr_q    <= rx[AW-1:0];
                        addr_ok_q <= addr_ok;
                        if (!addr_ok) err_q <= 1'b1;
                        if (op_q == OP_RD) begin
                            word_q <= rd_word;
                            tx_q   <= rd_word[31:24];
                        end
                    end
                    S_DATA: begin
                        idx_q   <= idx_q + 2'd1;
                        wdata_q <= {wdata_q[WDW-9:0], rx};
                        if (op_q != OP_WR) begin
                            if (idx_q != 2'd3) tx_q <= byte_of(word_q, idx_q + 2'd1);
`ifdef SPI_CMD_CHKSUM_EN
                            else tx_q <= xor4(word_q);
`endif
                        end
                    end
                    S_CHK: begin
`ifdef SPI_CMD_CHKSUM_EN
                        if (op_q == OP_WR && addr_ok_q && !commit) err_q <= 1'b1;
`endif
                    end
                    S_DRAIN: begin
                    end
                endcase
                if (commit) begin
                    reg_q[addr_q] <= commit_data;
                    wr_stb        <= 1'b1;
                    wr_addr       <= addr_q;
                    if (addr_q == '0) err_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder: directed frame table, hand sequences and random frames
// checked against a frame-level reference model of the command protocol.

module tb_spi_cmd_decoder;

    localparam int NREG = 4;
`ifdef SPI_CMD_CHKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        int          n;
        logic        cv;
        logic [31:0] cnt;
        logic [63:0] b;
        logic [63:0] e;
        int          ewr;
        logic [7:0]  est;
    } vec_t;

    logic               sysClk = 1'b0;
    logic               reset = 1'b1;
    logic [7:0]         rx = 8'h00;
    logic               rxValid = 1'b0;
    logic               ss_active = 1'b0;
    logic [31:0]        count = 32'h0;
    logic               count_valid = 1'b0;
    logic [7:0]         tx;
    logic [32*NREG-1:0] regs;
    logic               wr_stb;
    logic [1:0]         wr_addr;

    spi_cmd_decoder #(.NREG(NREG), .STATUS_ID(4'hA)) dut (
        .sysClk(sysClk), .reset(reset), .rx(rx), .rxValid(rxValid),
        .ss_active(ss_active), .count(count), .count_valid(count_valid),
        .tx(tx), .regs(regs), .wr_stb(wr_stb), .wr_addr(wr_addr)
    );

    always #5 sysClk = ~sysClk;

    int vecs = 0;
    int miscompares = 0;
    int wr_seen = 0;
    logic [1:0] last_wr = 2'd0;

    // count strobe cycles so a stretched pulse shows up as an extra write
    always @(negedge sysClk) begin
        if (wr_stb === 1'b1) begin
            wr_seen = wr_seen + 1;
            last_wr = wr_addr;
        end
    end

    logic [31:0] mregs [NREG];
    logic        merr;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic check_regs(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] x4(input logic [31:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] w, input int k);
        return w[31-8*k -: 8];
    endfunction

    function automatic logic [127:0] mflat();
        return {mregs[3], mregs[2], mregs[1], mregs[0]};
    endfunction

    function automatic logic [7:0] status(input logic e, input logic cv);
        return {4'hA, 2'b00, e, cv};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        rxValid = 1'b0;
        ss_active = 1'b0;
        count_valid = 1'b0;
        repeat (2) @(posedge sysClk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < NREG; i++) mregs[i] = 32'h0;
        merr = 1'b0;
        @(posedge sysClk);
        #1;
    endtask

    // host side of one SS frame: tx is what shifts out during each byte slot
    task automatic run_frame(input logic [7:0] b[10], input int n, input logic [31:0] cnt,
                             input logic cv, output logic [7:0] got[10]);
        count = cnt;
        count_valid = cv;
        ss_active = 1'b1;
        for (int i = 0; i < 10; i++) got[i] = 8'h00;
        @(posedge sysClk);
        #1;
        for (int i = 0; i < n; i++) begin
            got[i] = tx;
            rx = b[i];
            rxValid = 1'b1;
            @(posedge sysClk);
            #1;
            rxValid = 1'b0;
            if (i == 0) count = $urandom;
            @(posedge sysClk);
            #1;
        end
        ss_active = 1'b0;
        @(posedge sysClk);
        #1;
        @(posedge sysClk);
        #1;
    endtask

    // whole-frame reference: expected host bytes and register/error effects
    task automatic model_frame(input logic [7:0] b[10], input int n, input logic [31:0] cnt,
                               input logic cv, output logic [7:0] exp[10],
                               output int ewr, output int eaddr);
        logic [31:0] w;
        int a;
        int need;
        for (int i = 0; i < 10; i++) exp[i] = 8'h00;
        ewr = 0;
        eaddr = 0;
        exp[0] = status(merr, cv);
        a = int'(b[1]);
        need = CHK ? 7 : 6;
        case (b[0])
            8'h01: begin
                if (n >= 2 && a >= NREG) merr = 1'b1;
                if (n >= need && a < NREG) begin
                    w = {b[2], b[3], b[4], b[5]};
                    if (!CHK || b[6] == x4(w)) begin
                        mregs[a] = w;
                        ewr = 1;
                        eaddr = a;
                        if (a == 0) merr = 1'b0;
                    end else begin
                        merr = 1'b1;
                    end
                end
            end
            8'h02: begin
                if (n >= 2) begin
                    w = (a < NREG) ? mregs[a] : 32'h0;
                    if (a >= NREG) merr = 1'b1;
                    for (int k = 0; k < 4; k++) exp[2+k] = byte_at(w, k);
                    if (CHK) exp[6] = x4(w);
                end
            end
            8'h03: begin
                for (int k = 0; k < 4; k++) exp[1+k] = byte_at(cnt, k);
                if (CHK) exp[5] = x4(cnt);
            end
            default: merr = 1'b1;
        endcase
    endtask

    task automatic model_check(input logic [7:0] b[10], input int n, input logic [31:0] cnt,
                               input logic cv, input string tag);
        logic [7:0] exp[10];
        logic [7:0] got[10];
        int ewr;
        int eaddr;
        int w0;
        model_frame(b, n, cnt, cv, exp, ewr, eaddr);
        w0 = wr_seen;
        run_frame(b, n, cnt, cv, got);
        for (int i = 0; i < n; i++)
            check($sformatf("%s tx[%0d]", tag, i), 32'(got[i]), 32'(exp[i]));
        check($sformatf("%s wr_count", tag), wr_seen - w0, ewr);
        if (ewr == 1) check($sformatf("%s wr_addr", tag), 32'(last_wr), eaddr);
        check_regs($sformatf("%s regs", tag), regs, mflat());
        check($sformatf("%s status", tag), 32'(tx), 32'(status(merr, cv)));
    endtask

    initial begin
        vec_t tbl[10];
        logic [7:0] bb[10];
        logic [7:0] got[10];
        int w0;
        int L;
        int n;
        int r;

        tbl[0] = '{6, 1'b0, 32'h0, 64'h0101123456780000, 64'hA000000000000000, 1, 8'hA0};
        tbl[1] = '{6, 1'b0, 32'h0, 64'h0201000000000000, 64'hA000123456780000, 0, 8'hA0};
        tbl[2] = '{6, 1'b1, 32'h00C0FFEE, 64'h0300000000000000, 64'hA100C0FFEE000000, 0, 8'hA1};
        tbl[3] = '{3, 1'b0, 32'h0, 64'h7F05060000000000, 64'hA000000000000000, 0, 8'hA2};
        tbl[4] = '{6, 1'b0, 32'h0, 64'h0207000000000000, 64'hA200000000000000, 0, 8'hA2};
        tbl[5] = '{6, 1'b0, 32'h0, 64'h0107112233440000, 64'hA200000000000000, 0, 8'hA2};
        tbl[6] = '{6, 1'b0, 32'h0, 64'h0100000000000000, 64'hA200000000000000, 1, 8'hA0};
        tbl[7] = '{8, 1'b0, 32'h0, 64'h0103DEADBEEF5566, 64'hA000000000000000, 1, 8'hA0};
        tbl[8] = '{7, 1'b0, 32'h0, 64'h0203000000000000, 64'hA000DEADBEEF0000, 0, 8'hA0};
        tbl[9] = '{6, 1'b1, 32'h0, 64'h0201000000000000, 64'hA100123456780000, 0, 8'hA1};

        do_reset();
        check("reset tx", 32'(tx), 32'h000000A0);
        check_regs("reset regs", regs, 128'h0);
        check("reset wr_stb", 32'(wr_stb), 32'h0);
        count_valid = 1'b1;
        #1;
        check("reset tx cv", 32'(tx), 32'h000000A1);
        count_valid = 1'b0;

`ifndef SPI_CMD_CHKSUM_EN
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 10; i++) bb[i] = (i < 8) ? tbl[t].b[63-8*i -: 8] : 8'h00;
            w0 = wr_seen;
            run_frame(bb, tbl[t].n, tbl[t].cnt, tbl[t].cv, got);
            for (int i = 0; i < tbl[t].n; i++)
                check($sformatf("tbl%0d tx[%0d]", t, i), 32'(got[i]), 32'(tbl[t].e[63-8*i -: 8]));
            check($sformatf("tbl%0d wr_count", t), wr_seen - w0, tbl[t].ewr);
            check($sformatf("tbl%0d status", t), 32'(tx), 32'(tbl[t].est));
        end
        check_regs("tbl regs", regs, 128'hDEADBEEF_00000000_12345678_00000000);
`endif

        do_reset();

        bb = '{8'h01, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        bb[6] = x4(32'h11223344);
        model_check(bb, 7, 32'h0, 1'b0, "wr2");
        bb = '{8'h01, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h00, 8'h00, 8'h00};
        model_check(bb, 4, 32'h0, 1'b0, "abort_wr");
        bb = '{8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        model_check(bb, 7, 32'h0, 1'b1, "rd2");
        model_check(bb, 3, 32'h0, 1'b0, "abort_rd");
        rx = 8'h01;
        rxValid = 1'b1;
        @(posedge sysClk);
        #1;
        rxValid = 1'b0;
        model_check(bb, 7, 32'h0, 1'b0, "ss_low_rx");
        bb = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h55, 8'h00, 8'h00, 8'h00};
        model_check(bb, 7, 32'h0, 1'b0, "badchk");
        bb = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        model_check(bb, 7, 32'h00C0FFEE, 1'b1, "cnt");

        for (int f = 0; f < 250; f++) begin
            for (int i = 0; i < 10; i++) bb[i] = 8'($urandom);
            r = $urandom_range(0, 9);
            bb[1] = 8'($urandom_range(0, 5));
            if (r < 4) begin
                bb[0] = 8'h01;
                if ($urandom_range(0, 4) != 0) bb[6] = x4({bb[2], bb[3], bb[4], bb[5]});
                L = CHK ? 7 : 6;
            end else if (r < 7) begin
                bb[0] = 8'h02;
                L = CHK ? 7 : 6;
            end else if (r < 9) begin
                bb[0] = 8'h03;
                L = CHK ? 6 : 5;
            end else begin
                L = 1;
            end
            if ($urandom_range(0, 3) != 0) n = L + $urandom_range(0, 2);
            else n = $urandom_range(1, L);
            if (n > 10) n = 10;
            model_check(bb, n, $urandom, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", f));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
